alu_control: RTL

Multi-cycle control sequencer that sits between instruction fetch and the 16-bit ALU/register file. It accepts one 16-bit instruction word per handshake, decodes it, drives the 3-bit ALU opcode and operand selects, and latches the Z/C/N/V flags. It also controls register writeback and owns the program counter, including relative jumps and branch-if-zero.

---
 rtl/subarashii_pkg.sv | 41 ++++
 rtl/alu_control_decode.sv | 56 +++++
 rtl/alu_control.sv | 139 +++++++++++++
 3 files changed

// File: rtl/subarashii_pkg.sv
// Shared constants for the alu_control sequencer: ALU op codes,
// instruction opcodes, state encoding and instruction field positions.
package subarashii_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_NOT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_LSR = 3'b110;
    localparam logic [2:0] ALU_LSL = 3'b111;

    localparam logic [3:0] OP_ADI = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_BZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
    localparam logic [2:0] S_HALT      = 3'd4;

    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 8;
    localparam int RS_MSB   = 7;
    localparam int RS_LSB   = 4;
    localparam int RT_MSB   = 3;
    localparam int RT_LSB   = 0;
    localparam int IMM8_MSB = 7;
    localparam int IMM8_LSB = 0;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/alu_control_decode.sv
// Combinational instruction decoder for alu_control.
// Ports: ir_i (instruction) -> alu_op_o, b_imm_sel_o and class flags.
module alu_control_decode
    import subarashii_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  alu_op_o,
    output logic        b_imm_sel_o,
    output logic        writes_rd_o,
    output logic        sets_flags_o,
    output logic        is_branch_o,
    output logic        is_halt_o,
    output logic        is_illegal_o
);

    logic [3:0] opc;
    assign opc = ir_i[OPC_MSB:OPC_LSB];

    always_comb begin
        alu_op_o     = ALU_ADD;
        b_imm_sel_o  = 1'b0;
        writes_rd_o  = 1'b0;
        sets_flags_o = 1'b0;
        is_branch_o  = 1'b0;
        is_halt_o    = 1'b0;
        is_illegal_o = 1'b0;
        unique case (1'b1)
            (opc[3] == 1'b0): begin
                alu_op_o     = opc[2:0];
                writes_rd_o  = 1'b1;
                sets_flags_o = 1'b1;
            end
            (opc == OP_ADI): begin
                alu_op_o     = ALU_ADD;
                b_imm_sel_o  = 1'b1;
                writes_rd_o  = 1'b1;
                sets_flags_o = 1'b1;
            end
            (opc == OP_CMP): begin
                alu_op_o     = ALU_SUB;
                sets_flags_o = 1'b1;
            end
            (opc == OP_JMP),
            (opc == OP_BZ): begin
                is_branch_o = 1'b1;
            end
            (opc == OP_HLT): begin
                is_halt_o = 1'b1;
            end
            default: begin
                is_illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// Multi-cycle ALU control sequencer: fetch handshake, decode, ALU
// control, flag latch, writeback pulse and program counter.
// Ports: clk, rst_n, instr_valid/instr/instr_ready, fZ/fC/fN/fV in;
// alu_op, rs_addr, rt_addr, b_imm_sel, rf_we, rf_waddr, pc, flags,
// halted, illegal out.
// Option: ALU_CTRL_ILLEGAL_TRAP_EN makes undefined opcodes halt.
module alu_control
    import subarashii_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        fZ,
    input  logic        fC,
    input  logic        fN,
    input  logic        fV,
    output logic [2:0]  alu_op,
    output logic [3:0]  rs_addr,
    output logic [3:0]  rt_addr,
    output logic        b_imm_sel,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] pc,
    output logic [3:0]  flags,
    output logic        halted,
    output logic        illegal
);

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pc_q, pc_d;
    logic [3:0]  flags_q, flags_d;

    logic [2:0]  dec_op;
    logic        dec_bimm;
    logic        dec_wr;
    logic        dec_fl;
    logic        dec_br;
    logic        dec_hlt;
    logic        dec_ill;
    logic        take;

    alu_control_decode u_dec (
        .ir_i        (ir_q),
        .alu_op_o    (dec_op),
        .b_imm_sel_o (dec_bimm),
        .writes_rd_o (dec_wr),
        .sets_flags_o(dec_fl),
        .is_branch_o (dec_br),
        .is_halt_o   (dec_hlt),
        .is_illegal_o(dec_ill)
    );

    // JMP always taken; BZ taken on the flags latched before it.
    assign take = dec_br &&
        ((ir_q[OPC_MSB:OPC_LSB] == OP_JMP) || flags_q[3]);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_hlt) begin
                    state_d = S_HALT;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                end else if (dec_ill) begin
                    state_d = S_HALT;
`endif
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (dec_fl) begin
                    flags_d = {fZ, fC, fN, fV};
                end
                if (dec_wr) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_FETCH;
                    if (take) begin
                        pc_d = pc_q +
                            sext8(ir_q[IMM8_MSB:IMM8_LSB]);
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            end
            S_WRITEBACK: begin
                pc_d    = pc_q + 16'd1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= 16'h0000;
            pc_q    <= 16'h0000;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    // Outputs decode from state so async reset clears them at once.
    assign instr_ready = (state_q == S_FETCH);
    assign alu_op      = (state_q == S_EXECUTE) ? dec_op : ALU_ADD;
    assign b_imm_sel   = (state_q == S_EXECUTE) && dec_bimm;
    assign rs_addr     = ir_q[RS_MSB:RS_LSB];
    assign rt_addr     = ir_q[RT_MSB:RT_LSB];
    assign rf_we       = (state_q == S_WRITEBACK);
    assign rf_waddr    = ir_q[RD_MSB:RD_LSB];
    assign pc          = pc_q;
    assign flags       = flags_q;
    assign halted      = (state_q == S_HALT);
    assign illegal     = (state_q == S_DECODE) && dec_ill;

endmodule
